// File: rtl/div_scheduler.sv
// Round-robin arbiter in front of one shared iterative radix-2 restoring divider.
// One quotient bit per cycle, results held on a shared bus until the next done.
module div_scheduler #(
  parameter int WIDTH = 24,
  parameter int NREQ  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   num_in,
  input  logic [NREQ*WIDTH-1:0]   den_in,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        quot,
  output logic [WIDTH-1:0]        rem,
  output logic                    div_by_zero
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    last_q, last_d, win_q, win_d;
  logic [IW-1:0]    pick;
  logic             pick_vld;
  logic [WIDTH-1:0] num_sel, den_sel;
  logic [WIDTH-1:0] num_q, num_d, den_q, den_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             fits;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_rem;

  // Round-robin pick, scanning from one past the last granted requester.
  always_comb begin
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last_q) + i) % NREQ;
      if (!pick_vld && req[IW'(idx)]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
    num_sel = '0;
    den_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        num_sel = num_in[i*WIDTH +: WIDTH];
        den_sel = den_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = ITER;
      ITER:    if (den_q == '0 || cnt_q == 5'(WIDTH-1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    grant = '0;
    done  = '0;
    if (state_q != IDLE) grant[win_q] = 1'b1;
    if (state_q == DONE) done[win_q]  = 1'b1;
  end

  // prem_q holds the already-shifted partial remainder ready for the trial
  // subtraction; num_q shifts dividend bits out the top and quotient bits in.
  always_comb begin
    fits     = (prem_q >= {1'b0, den_q});
    diff     = prem_q - {1'b0, den_q};
    step_rem = fits ? diff[WIDTH-1:0] : prem_q[WIDTH-1:0];
    last_d = last_q;
    win_d  = win_q;
    num_d  = num_q;
    den_d  = den_q;
    prem_d = prem_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          win_d  = pick;
          num_d  = {num_sel[WIDTH-2:0], 1'b0};
          den_d  = den_sel;
          prem_d = {{WIDTH{1'b0}}, num_sel[WIDTH-1]};
          cnt_d  = '0;
        end
      end
      ITER: begin
        if (den_q == '0) begin
          // Dividend reassembled from its pre-shifted capture form.
          quot_d = '1;
          rem_d  = {prem_q[0], num_q[WIDTH-1:1]};
          dbz_d  = 1'b1;
        end else begin
          num_d  = {num_q[WIDTH-2:0], fits};
          prem_d = {step_rem, num_q[WIDTH-1]};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'(WIDTH-1)) begin
            quot_d = {num_q[WIDTH-2:0], fits};
            rem_d  = step_rem;
            dbz_d  = 1'b0;
          end
        end
      end
      DONE:    last_d = win_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q <= IW'(NREQ-1);
      win_q  <= '0;
      num_q  <= '0;
      den_q  <= '0;
      prem_q <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      win_q  <= win_d;
      num_q  <= num_d;
      den_q  <= den_d;
      prem_q <= prem_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: transaction-level countdown model compared every cycle,
// directed scenarios with literal expectations, then a randomized multi-requester sweep.
module tb_div_scheduler;
  localparam int W = 24;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] num_in, den_in;
  logic [N-1:0]   grant, done;
  logic           busy, div_by_zero;
  logic [W-1:0]   quot, rem;

  always #5 clk = ~clk;

  div_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .num_in(num_in), .den_in(den_in),
    .grant(grant), .busy(busy), .done(done), .quot(quot), .rem(rem),
    .div_by_zero(div_by_zero)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation owns the divider for a fixed number of cycles,
  // result computed with plain / and %.
  bit           started = 1'b0;
  bit           m_busy = 1'b0, m_done = 1'b0;
  int           m_own = 0, m_last = N-1, m_left = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
  logic         m_z = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      started = 1'b1;
      m_busy = 1'b0; m_done = 1'b0; m_last = N-1;
      m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int w;
        w = (m_last + k) % N;
        if (!m_busy && req[w]) begin
          m_busy = 1'b1;
          m_own  = w;
          m_a    = num_in[w*W +: W];
          m_b    = den_in[w*W +: W];
          m_left = (m_b == '0) ? 1 : W;
        end
      end
    end else if (m_done) begin
      m_done = 1'b0; m_busy = 1'b0; m_last = m_own;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        if (m_b == '0) begin
          m_q = '1; m_r = m_a; m_z = 1'b1;
        end else begin
          m_q = m_a / m_b; m_r = m_a % m_b; m_z = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg, ed;
    if (started) begin
      eg = m_busy ? (N'(1) << m_own) : '0;
      ed = m_done ? (N'(1) << m_own) : '0;
      check("grant", 64'(grant), 64'(eg));
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(ed));
      check("quot", 64'(quot), 64'(m_q));
      check("rem", 64'(rem), 64'(m_r));
      check("div_by_zero", 64'(div_by_zero), 64'(m_z));
      if (m_done && m_b != '0) begin
        check("identity", 64'(quot) * 64'(m_b) + 64'(rem), 64'(m_a));
        check("rem_lt_den", 64'(rem < m_b), 64'(1));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    num_in[i*W +: W] = a;
    den_in[i*W +: W] = b;
  endtask

  task automatic do_reset;
    req = '0;
    rst = 1'b0;
    tick;
    rst = 1'b1;
  endtask

  task automatic wait_done(input int idx, output int edges, output bit found);
    edges = 0;
    found = 1'b0;
    while (!found && edges < 200) begin
      tick;
      edges++;
      if (done[idx]) found = 1'b1;
    end
  endtask

  task automatic wait_any(output int idx, output int edges, output bit found);
    edges = 0;
    found = 1'b0;
    idx   = -1;
    while (!found && edges < 200) begin
      tick;
      edges++;
      for (int i = 0; i < N; i++) if (done[i]) begin idx = i; found = 1'b1; end
    end
  endtask

  task automatic rand_op(input int i);
    logic [W-1:0] a, b;
    case ($urandom % 4)
      0:       a = '1;
      1:       a = W'($urandom % 1000);
      default: a = W'($urandom);
    endcase
    case ($urandom % 8)
      0: b = W'(1);
      1: b = '0;
      2: b = (a < W'(24'hFFFF00)) ? a + W'(1 + $urandom % 200) : '1;
      3: b = W'(1 + $urandom % 255);
      4: begin
        b = W'($urandom) >> ($urandom % W);
        if (b == '0) b = W'(3);
      end
      default: b = W'($urandom);
    endcase
    set_op(i, a, b);
  endtask

  initial begin
    int e, idx, completed, guard;
    bit f;
    rst = 1'b0; req = '0; num_in = '0; den_in = '0;
    tick; tick;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_quot", 64'(quot), 64'(0));
    check("rst_rem", 64'(rem), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    rst = 1'b1;

    // Single request: k = 800000 / 160000
    set_op(0, W'(800000), W'(160000));
    req[0] = 1'b1;
    tick;
    check("single_grant", 64'(grant), 64'(3'b001));
    wait_done(0, e, f);
    check("single_found", 64'(f), 64'(1));
    check("single_latency", 64'(e), 64'(24));
    check("single_quot", 64'(quot), 64'(5));
    check("single_rem", 64'(rem), 64'(0));
    check("single_dbz", 64'(div_by_zero), 64'(0));
    req[0] = 1'b0;
    tick;
    check("single_pulse", 64'(done), 64'(0));
    tick;

    // Simultaneous requests
    do_reset;
    set_op(0, W'(500000), W'(100));
    set_op(1, W'(5000), W'(100));
    req = 3'b011;
    wait_done(0, e, f);
    check("simul0_found", 64'(f), 64'(1));
    check("simul0_quot", 64'(quot), 64'(5000));
    check("simul0_rem", 64'(rem), 64'(0));
    req[0] = 1'b0;
    wait_done(1, e, f);
    check("simul1_found", 64'(f), 64'(1));
    check("simul1_quot", 64'(quot), 64'(50));
    check("simul1_gap", 64'(e), 64'(26));
    req[1] = 1'b0;
    tick; tick;

    // Fairness with all requests held
    do_reset;
    set_op(0, W'(1000), W'(7));
    set_op(1, W'(2000), W'(9));
    set_op(2, W'(3000), W'(11));
    req = 3'b111;
    for (int j = 0; j < 6; j++) begin
      wait_any(idx, e, f);
      check("fair_found", 64'(f), 64'(1));
      check("fair_order", 64'(idx), 64'(j % 3));
      if (j > 0) check("fair_gap", 64'(e), 64'(26));
    end
    req = '0;
    tick; tick;

    // Divide by zero, then a normal divide on a held request
    do_reset;
    set_op(0, W'(1234), W'(0));
    req[0] = 1'b1;
    tick;
    wait_done(0, e, f);
    check("dbz_latency", 64'(e), 64'(1));
    check("dbz_quot", 64'(quot), 64'(24'hFFFFFF));
    check("dbz_rem", 64'(rem), 64'(1234));
    check("dbz_flag", 64'(div_by_zero), 64'(1));
    set_op(0, W'(7), W'(2));
    wait_done(0, e, f);
    check("after_dbz_gap", 64'(e), 64'(26));
    check("after_dbz_quot", 64'(quot), 64'(3));
    check("after_dbz_rem", 64'(rem), 64'(1));
    check("after_dbz_flag", 64'(div_by_zero), 64'(0));
    req = '0;
    tick; tick;

    // Reset during iteration 10 of a divide on requester 2
    set_op(2, W'(999999), W'(77));
    req[2] = 1'b1;
    tick;
    for (int j = 0; j < 10; j++) begin
      tick;
      check("midop_nodone", 64'(done), 64'(0));
    end
    req = '0;
    rst = 1'b0;
    tick;
    check("midop_grant", 64'(grant), 64'(0));
    check("midop_busy", 64'(busy), 64'(0));
    check("midop_done", 64'(done), 64'(0));
    check("midop_quot", 64'(quot), 64'(0));
    check("midop_rem", 64'(rem), 64'(0));
    rst = 1'b1;
    set_op(0, W'(81), W'(9));
    set_op(2, W'(100), W'(10));
    req = 3'b101;
    tick;
    check("prio_grant", 64'(grant), 64'(3'b001));
    wait_done(0, e, f);
    check("prio_quot", 64'(quot), 64'(9));
    req[0] = 1'b0;
    wait_done(2, e, f);
    check("prio2_quot", 64'(quot), 64'(10));
    req = '0;
    tick; tick;

    // Randomized sweep across all requesters
    completed = 0;
    guard = 0;
    while (completed < 1000 && guard < 60000) begin
      tick;
      guard++;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          completed++;
          if ($urandom % 2 == 0) req[i] = 1'b0;
          else rand_op(i);
        end else if (!req[i] && $urandom % 3 == 0) begin
          rand_op(i);
          req[i] = 1'b1;
        end
      end
    end
    check("sweep_complete", 64'(completed >= 1000), 64'(1));
    req = '0;
    tick; tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_scheduler.md
# div_scheduler

Shares one iterative radix-2 restoring divider between up to NREQ requesters. It replaces the per-use combinational dividers in the sequence-decomposer top level: the sample-count k = Fs*100/(Vref_freq*N) and the frequency scaling Vref_freq/100. It sits between the frequency measurement and the adaptive-sampling clock logic. Arbitration is round-robin with a req/done handshake, and results are presented on one shared result bus.

## Interface

Parameters:
- WIDTH, 24, operand, quotient and remainder width (unsigned)
- NREQ, 3, number of requesters (2..8)

Ports:
- clk  in  1  system clock (100 MHz domain)
- rst  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester request; hold high with operands stable until its done pulse
- num_in  in  NREQ*WIDTH  dividends, requester i at [i*WIDTH +: WIDTH]
- den_in  in  NREQ*WIDTH  divisors, same packing
- grant  out  NREQ  one-hot, high for the whole operation of the granted requester
- busy  out  1  high from capture until the DONE state exits
- done  out  NREQ  one-cycle pulse to the granted requester when the result is valid
- quot  out  WIDTH  quotient, held until the next result
- rem  out  WIDTH  remainder, held until the next result
- div_by_zero  out  1  flag for the last result; valid with done, held with quot

## Operation

- States: IDLE, ITER, DONE.
- IDLE behaviour:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the winner by round-robin, starting one past the last granted index and wrapping at NREQ-1.
  - Latch the winner's num/den, set grant[winner] and busy.
- Zero-divisor branch:
  - A zero divisor jumps straight to DONE on the next edge.
  - Outputs: quot = all ones, rem = num, div_by_zero = 1.
  - No iterations are run.
- ITER state:
  - One restoring step per cycle, MSB first, for WIDTH cycles.
  - The partial remainder register is WIDTH+1 bits wide to hold the trial subtraction.
  - A 5-bit iteration counter (sufficient for WIDTH ≤ 32) controls the step count.
- Leaving ITER:
  - On the last step, load quot/rem and clear div_by_zero.
  - Set done[winner] and go to DONE.
- DONE state:
  - Lasts exactly one cycle.
  - On exit, clear done, grant and busy, and return to IDLE.
  - Update the last-granted pointer to the winner.
- Req handling during an operation:
  - Requests are sampled only in IDLE.
  - Dropping req mid-operation does not abort the operation; done still pulses.
  - Operand changes after capture are ignored.
- Repeat requests: a req still high in the first IDLE cycle after DONE is a new request.
- Width rules:
  - Everything is unsigned; no rounding.
  - quot*den + rem == num holds for den ≠ 0.

## Timing

- Reset (rst low at an edge): the following are all 0:
  - state = IDLE
  - grant, busy, done
  - quot, rem, div_by_zero
- Reset also sets the last-granted pointer to NREQ-1, so requester 0 has the highest priority.
- Reset mid-operation aborts the operation with no done pulse.
- Latency, counting from the edge E0 that samples req in IDLE:
  - grant and busy are high from E0.
  - Normal divide: done is high in the cycle after E(WIDTH); DONE exits at E(WIDTH+1); the next sample is at E(WIDTH+2).
  - Zero divisor: done is high in the cycle after E1; the next sample is at E3.
- Throughput: one normal divide per WIDTH+2 cycles.
- Simultaneous requests: exactly one grant per operation; the rest wait in round-robin order.
- Valid window: quot/rem/div_by_zero change only on the edge that raises done.

## Test plan

- Single request: WIDTH=24, req[0] with num=800000, den=160000 (k for Fs=8000, Vref_freq=5000, N=32).
  - quot=5, rem=0, div_by_zero=0.
  - done[0] high for exactly 1 cycle, 24 cycles after the sampling edge.
  - grant[0] high for the whole operation.
- Simultaneous requests: req[0] with num=500000, den=100 and req[1] with num=5000, den=100 raised on the same cycle.
  - done[0] first, with quot=5000, rem=0.
  - done[1] 26 cycles later, with quot=50.
  - grant is never two-hot.
- Fairness: req[0..2] held high continuously.
  - Grant order 0,1,2,0,1,2.
  - Each done is 26 cycles apart.
- Divide by zero: num=1234, den=0.
  - quot=0xFFFFFF, rem=1234, div_by_zero=1.
  - done 1 cycle after sampling.
  - A following divide of 7/2 gives quot=3, rem=1, div_by_zero=0.
- Reset mid-operation: rst low at iteration 10 of a divide on req[2].
  - No done pulse.
  - grant, busy, quot, rem all 0 after the reset edge.
  - With req[0] and req[2] both high after reset, requester 0 is granted first.
- Randomized sweep: 1000 random num/den pairs, including den=1, den > num and num = 2^24-1.
  - quot*den + rem == num and rem < den for every result.
